alarm_clock_core: RTL and testbench
===================================

// Module: alarm_clock_core
// PURPOSE
//  Parametrised timekeeper: 24h binary time, NUM_ALARMS alarm registers, snooze and ring timeout.
//  Provides time/alarm display in 12h or 24h BCD and a ring request that gates the tone generator.
//  Keys are active-low and already synchronised by the top level.
// PARAMETERS
//  CLK_HZ          50_000_000  clock cycles per second; prescaler counts 0..CLK_HZ-1
//  NUM_ALARMS      2           alarm registers, 1..4; localparam AW = max(1,$clog2(NUM_ALARMS))
//  SNOOZE_MIN      9           snooze length in minutes, 1..59
//  RING_TIMEOUT_S  60          seconds in RING before auto-stop, 1..255
// PORTS
//  CLOCK_50     in   1           clock
//  AUD_DACLRCK  in   1           reset, asynchronous, active-low
//  inc_hr_n     in   1           hour-increment key, active-low
//  inc_min_n    in   1           minute-increment key, active-low
//  snooze_n     in   1           snooze key, active-low
//  stop_n       in   1           stop key, active-low
//  set_sel      in   1           0 = edit/show time, 1 = edit/show alarm[alm_sel]
//  alm_sel      in   AW          alarm index for edit/display
//  alm_en       in   NUM_ALARMS  per-alarm enable
//  mode24       in   1           1 = 24h display, 0 = 12h display
//  disp_hr      out  8           BCD hours {tens,ones}
//  disp_min     out  8           BCD minutes
//  disp_sec     out  8           BCD seconds; 8'h00 when set_sel=1
//  disp_pm      out  1           hour>=12 of shown value; 0 when mode24=1
//  sec_tick     out  1           one-cycle pulse per elapsed second
//  ring         out  1           1 in RING
//  ring_id      out  AW          index of the alarm that caused RING/SNOOZE
//  snoozed      out  1           1 in SNOOZE
// BEHAVIOUR
//  Reset: time 00:00:00, all alarms 00:00, prescaler 0, state IDLE, key history 1.
//   Outputs: ring=0, snoozed=0, ring_id=0, sec_tick=0, disp = 12:00:00 pm=0 (mode24=0) or 00:00:00.
//  sec_tick=1 in the cycle the prescaler wraps. Time advances on the same edge.
//   Full carry in one cycle: sec 59->0 min+1; min 59->0 hr+1; hr 23->0.
//  Keys act on the falling edge only; one increment per press; holding a key does nothing more.
//   Time edit (set_sel=0): hr+1 mod 24; min+1 mod 60 with no hour carry.
//    A minute edit also clears sec and the prescaler.
//    If an edit and sec_tick fall in the same cycle, the edit applies and that tick is dropped.
//   Alarm edit (set_sel=1): alarm[alm_sel] hr/min mod 24/60. alm_sel>=NUM_ALARMS is ignored.
//  12h map: hr 0 -> 12 AM; 1..11 AM; 12 -> 12 PM; 13..23 -> 1..11 PM. Display is combinational from registers.
//  Match: new_sec is sec_tick delayed one cycle.
//   In a new_sec cycle with sec==0, alarm i matches if alm_en[i] && hr/min == alarm[i].
//   Lowest matching index wins. ring asserts one cycle after new_sec.
//  FSM:
//   IDLE   -> RING on match; ring_id=i, ring_cnt=0.
//   RING   -> IDLE on stop edge, or when ring_cnt reaches RING_TIMEOUT_S (ring_cnt +1 per sec_tick).
//          -> SNOOZE on snooze edge; snz_cnt = SNOOZE_MIN*60.
//          A new match is ignored; ring_id is held.
//   SNOOZE -> snz_cnt-1 per sec_tick; at 0 -> RING with ring_cnt=0.
//          -> IDLE on stop edge.
//          -> RING on a new match; ring_id=new i.
//   In RING or SNOOZE: alm_en[ring_id]=0 -> IDLE next cycle.
//   Stop and snooze edges in the same cycle: stop wins.
//   Alarm edits never abort RING/SNOOZE.
//  Reset mid-operation clears everything asynchronously. ring drops with no clock.
// STRUCTURE
//  alarm_clock_pkg: state enum {IDLE,RING,SNOOZE}; SEC_PER_MIN/MIN_PER_HR/HR_PER_DAY;
//   function bin_to_bcd8(6-bit); function hr_to_12(5-bit) -> {pm,bcd8}.
//  Sub-module alarm_key_edge: per-key history register + falling-edge pulse, instanced x4.
// TESTING (CLK_HZ=10, SNOOZE_MIN=1, RING_TIMEOUT_S=5)
//  Reset, mode24=0 -> disp 12:00:00 pm=0, ring=0; mode24=1 -> 00:00:00; sec_tick every 10 cycles.
//  Edit to 23:59:58, wait 2 ticks -> 00:00:00; min key held 30 cycles -> +1 only, sec=0.
//  alarm0=00:01, alm_en=01, time 00:00:59 -> ring=1, ring_id=0 two cycles after sec_tick.
//  In RING, snooze edge -> snoozed=1, ring=0; 60 ticks later ring=1; stop edge -> IDLE.
//  Ring with no keys -> ring=0 after 5 ticks; alarms 0,1 both 00:01 -> ring_id=0.
//  Stop+snooze same cycle -> IDLE; clear alm_en[0] in RING -> IDLE; reset mid-RING -> ring=0 at once.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared types, constants and
// BCD helpers for the alarm clock core.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int MIN_PER_HR  = 60;
  localparam int HR_PER_DAY  = 24;

  // Binary 0..63 to two BCD digits {tens,ones}.
  function automatic logic [7:0] bin_to_bcd8(
    input logic [5:0] v
  );
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 6'd10);
    o = 4'(v % 6'd10);
    return {t, o};
  endfunction

  // 24h hour to {pm, 12h BCD hour}.
  function automatic logic [8:0] hr_to_12(
    input logic [4:0] h
  );
    logic [4:0] h12;
    unique case (1'b1)
      (h == 5'd0): h12 = 5'd12;
      (h > 5'd12): h12 = h - 5'd12;
      default:     h12 = h;
    endcase
    return {(h >= 5'd12), bin_to_bcd8({1'b0, h12})};
  endfunction

endpackage

// File: rtl/alarm_clock_core_key_edge.sv
// alarm_key_edge: history register and
// falling-edge pulse for one active-low key.
module alarm_key_edge (
  input  logic CLOCK_50,
  input  logic AUD_DACLRCK,
  input  logic key_n,
  output logic fall
);

  logic hist;

  // Remember last key level; idles released.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) hist <= 1'b1;
    else              hist <= key_n;
  end

  assign fall = hist & ~key_n;

endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: 24h timekeeper with alarms,
// snooze, ring timeout and 12/24h BCD display.
module alarm_clock_core #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int NUM_ALARMS     = 2,
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic CLOCK_50,
  input  logic AUD_DACLRCK,
  input  logic inc_hr_n,
  input  logic inc_min_n,
  input  logic snooze_n,
  input  logic stop_n,
  input  logic set_sel,
  input  logic [((NUM_ALARMS > 1) ?
    $clog2(NUM_ALARMS) : 1)-1:0] alm_sel,
  input  logic [NUM_ALARMS-1:0] alm_en,
  input  logic mode24,
  output logic [7:0] disp_hr,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic disp_pm,
  output logic sec_tick,
  output logic ring,
  output logic [((NUM_ALARMS > 1) ?
    $clog2(NUM_ALARMS) : 1)-1:0] ring_id,
  output logic snoozed
);

  import alarm_clock_pkg::*;

  localparam int AW =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int PW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(CLK_HZ - 1);
  localparam logic [5:0] SEC_LAST =
    6'(SEC_PER_MIN - 1);
  localparam logic [5:0] MIN_LAST =
    6'(MIN_PER_HR - 1);
  localparam logic [4:0] HR_LAST =
    5'(HR_PER_DAY - 1);
  localparam logic [7:0] RC_LAST =
    8'(RING_TIMEOUT_S - 1);
  localparam logic [11:0] SNZ_LOAD =
    12'(SNOOZE_MIN * SEC_PER_MIN);

  logic hr_e, min_e, snz_e, stop_e;
  logic [PW-1:0] presc;
  logic tick, t_edit, new_sec;
  logic [4:0] hr;
  logic [5:0] min, sec;
  logic [4:0] a_hr  [NUM_ALARMS];
  logic [5:0] a_min [NUM_ALARMS];
  logic match, en_cur;
  logic [AW-1:0] match_idx;
  state_t state, state_n;
  logic [AW-1:0] rid, rid_n;
  logic [7:0] ring_cnt, ring_cnt_n;
  logic [11:0] snz_cnt, snz_cnt_n;
  logic [4:0] sh;
  logic [5:0] sm;
  logic [8:0] h12;

  alarm_key_edge u_khr (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .key_n       (inc_hr_n),
    .fall        (hr_e)
  );

  alarm_key_edge u_kmin (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .key_n       (inc_min_n),
    .fall        (min_e)
  );

  alarm_key_edge u_ksnz (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .key_n       (snooze_n),
    .fall        (snz_e)
  );

  alarm_key_edge u_kstop (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .key_n       (stop_n),
    .fall        (stop_e)
  );

  assign tick     = (presc == P_LAST);
  assign sec_tick = tick;
  assign t_edit   = !set_sel && (hr_e || min_e);

  // Prescaler; a minute edit restarts the second.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK)          presc <= '0;
    else if (!set_sel && min_e) presc <= '0;
    else if (tick)             presc <= '0;
    else                       presc <= presc + 1'b1;
  end

  // Delayed tick used to qualify alarm matches.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) new_sec <= 1'b0;
    else              new_sec <= tick;
  end

  // Time of day: edits take precedence over a tick.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      hr  <= '0;
      min <= '0;
      sec <= '0;
    end else if (t_edit) begin
      if (hr_e)
        hr <= (hr == HR_LAST) ? '0 : hr + 5'd1;
      if (min_e) begin
        min <= (min == MIN_LAST) ? '0 : min + 6'd1;
        sec <= '0;
      end
    end else if (tick) begin
      if (sec == SEC_LAST) begin
        sec <= '0;
        if (min == MIN_LAST) begin
          min <= '0;
          hr  <= (hr == HR_LAST) ? '0 : hr + 5'd1;
        end else begin
          min <= min + 6'd1;
        end
      end else begin
        sec <= sec + 6'd1;
      end
    end
  end

  // Alarm registers; out-of-range selects hit nothing.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        a_hr[i]  <= '0;
        a_min[i] <= '0;
      end
    end else if (set_sel) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alm_sel == AW'(i)) begin
          if (hr_e)
            a_hr[i] <= (a_hr[i] == HR_LAST) ?
              '0 : a_hr[i] + 5'd1;
          if (min_e)
            a_min[i] <= (a_min[i] == MIN_LAST) ?
              '0 : a_min[i] + 6'd1;
        end
      end
    end
  end

  // Lowest enabled alarm equal to hh:mm at :00.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (new_sec && sec == 6'd0 && alm_en[i] &&
          hr == a_hr[i] && min == a_min[i]) begin
        match     = 1'b1;
        match_idx = AW'(i);
      end
    end
  end

  // Enable bit of the alarm currently ringing.
  always_comb begin
    en_cur = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (rid == AW'(i)) en_cur = alm_en[i];
  end

  // FSM state and counters.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      state    <= IDLE;
      rid      <= '0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      state    <= state_n;
      rid      <= rid_n;
      ring_cnt <= ring_cnt_n;
      snz_cnt  <= snz_cnt_n;
    end
  end

  // FSM next state; stop outranks snooze.
  always_comb begin
    state_n    = state;
    rid_n      = rid;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    unique case (state)
      IDLE: begin
        if (match) begin
          state_n    = RING;
          rid_n      = match_idx;
          ring_cnt_n = '0;
        end
      end
      RING: begin
        if (!en_cur || stop_e) begin
          state_n = IDLE;
        end else if (tick && ring_cnt == RC_LAST) begin
          state_n = IDLE;
        end else if (snz_e) begin
          state_n   = SNOOZE;
          snz_cnt_n = SNZ_LOAD;
        end else if (tick) begin
          ring_cnt_n = ring_cnt + 8'd1;
        end
      end
      SNOOZE: begin
        if (!en_cur || stop_e) begin
          state_n = IDLE;
        end else if (match) begin
          state_n    = RING;
          rid_n      = match_idx;
          ring_cnt_n = '0;
        end else if (tick) begin
          if (snz_cnt <= 12'd1) begin
            state_n    = RING;
            ring_cnt_n = '0;
            snz_cnt_n  = '0;
          end else begin
            snz_cnt_n = snz_cnt - 12'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign ring    = (state == RING);
  assign snoozed = (state == SNOOZE);
  assign ring_id = rid;

  // Pick the shown hh:mm: time or selected alarm.
  always_comb begin
    sh = '0;
    sm = '0;
    if (!set_sel) begin
      sh = hr;
      sm = min;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alm_sel == AW'(i)) begin
          sh = a_hr[i];
          sm = a_min[i];
        end
      end
    end
  end

  // BCD display in 12h or 24h form.
  always_comb begin
    h12      = hr_to_12(sh);
    disp_min = bin_to_bcd8(sm);
    disp_sec = set_sel ? 8'h00 : bin_to_bcd8(sec);
    if (mode24) begin
      disp_hr = bin_to_bcd8({1'b0, sh});
      disp_pm = 1'b0;
    end else begin
      disp_hr = h12[7:0];
      disp_pm = h12[8];
    end
  end

endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed checks of display,
// editing, alarm match, snooze, timeout and reset.
module tb_alarm_clock_core;

  logic CLOCK_50;
  logic AUD_DACLRCK;
  logic inc_hr_n, inc_min_n, snooze_n, stop_n;
  logic set_sel;
  logic [0:0] alm_sel;
  logic [1:0] alm_en;
  logic mode24;
  logic [7:0] disp_hr, disp_min, disp_sec;
  logic disp_pm, sec_tick, ring, snoozed;
  logic [0:0] ring_id;

  int checks;
  int failures;
  int cycle;

  typedef struct {
    int         presses;
    logic       m24;
    logic [7:0] hr;
    logic       pm;
  } vec_t;

  vec_t tbl[10];

  alarm_clock_core #(
    .CLK_HZ         (10),
    .NUM_ALARMS     (2),
    .SNOOZE_MIN     (1),
    .RING_TIMEOUT_S (5)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .inc_hr_n    (inc_hr_n),
    .inc_min_n   (inc_min_n),
    .snooze_n    (snooze_n),
    .stop_n      (stop_n),
    .set_sel     (set_sel),
    .alm_sel     (alm_sel),
    .alm_en      (alm_en),
    .mode24      (mode24),
    .disp_hr     (disp_hr),
    .disp_min    (disp_min),
    .disp_sec    (disp_sec),
    .disp_pm     (disp_pm),
    .sec_tick    (sec_tick),
    .ring        (ring),
    .ring_id     (ring_id),
    .snoozed     (snoozed)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
        nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
    cycle++;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    cyc();
    while (sec_tick !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    if (sec_tick !== 1'b1)
      chk("tick_timeout", 32'(sec_tick), 32'd1);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: inc_hr_n  = v;
      1: inc_min_n = v;
      2: snooze_n  = v;
      default: stop_n = v;
    endcase
  endtask

  task automatic press(input int k, input int hold);
    set_key(k, 1'b0);
    repeat (hold) cyc();
    set_key(k, 1'b1);
    cyc();
  endtask

  task automatic goto_ring(
    input logic [0:0] id,
    input string nm
  );
    int n;
    set_sel = 1'b0;
    mode24  = 1'b1;
    press(1, 1);
    n = 1;
    while (disp_min !== 8'h00 && n < 70) begin
      press(1, 1);
      n++;
    end
    chk({nm, "_min0"}, 32'(disp_min), 32'h00);
    chk({nm, "_hr_nocarry"}, 32'(disp_hr), 32'h00);
    repeat (59) wait_tick();
    cyc();
    chk({nm, "_sec59"}, 32'(disp_sec), 32'h59);
    wait_tick();
    chk({nm, "_ring_pre"}, 32'(ring), 32'd0);
    cyc();
    cyc();
    chk({nm, "_ring"}, 32'(ring), 32'd1);
    chk({nm, "_ring_id"}, 32'(ring_id), 32'(id));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c0;
    checks   = 0;
    failures = 0;
    cycle    = 0;
    tbl[0] = '{0,  1'b0, 8'h12, 1'b0};
    tbl[1] = '{0,  1'b1, 8'h00, 1'b0};
    tbl[2] = '{1,  1'b0, 8'h01, 1'b0};
    tbl[3] = '{10, 1'b0, 8'h11, 1'b0};
    tbl[4] = '{1,  1'b0, 8'h12, 1'b1};
    tbl[5] = '{0,  1'b1, 8'h12, 1'b0};
    tbl[6] = '{1,  1'b0, 8'h01, 1'b1};
    tbl[7] = '{10, 1'b0, 8'h11, 1'b1};
    tbl[8] = '{0,  1'b1, 8'h23, 1'b0};
    tbl[9] = '{1,  1'b1, 8'h00, 1'b0};

    AUD_DACLRCK = 1'b0;
    inc_hr_n  = 1'b1;
    inc_min_n = 1'b1;
    snooze_n  = 1'b1;
    stop_n    = 1'b1;
    set_sel   = 1'b0;
    alm_sel   = 1'b0;
    alm_en    = 2'b00;
    mode24    = 1'b0;
    #22;
    chk("rst_hr12", 32'(disp_hr), 32'h12);
    chk("rst_min", 32'(disp_min), 32'h00);
    chk("rst_sec", 32'(disp_sec), 32'h00);
    chk("rst_pm", 32'(disp_pm), 32'd0);
    chk("rst_ring", 32'(ring), 32'd0);
    chk("rst_snz", 32'(snoozed), 32'd0);
    chk("rst_id", 32'(ring_id), 32'd0);
    chk("rst_tick", 32'(sec_tick), 32'd0);
    mode24 = 1'b1;
    #1;
    chk("rst_hr24", 32'(disp_hr), 32'h00);
    @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b1;

    wait_tick();
    c0 = cycle;
    wait_tick();
    chk("tick_period", 32'(cycle - c0), 32'd10);

    set_sel = 1'b1;
    alm_sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].presses) press(0, 1);
      mode24 = tbl[i].m24;
      #1;
      chk($sformatf("tbl%0d_hr", i),
        32'(disp_hr), 32'(tbl[i].hr));
      chk($sformatf("tbl%0d_pm", i),
        32'(disp_pm), 32'(tbl[i].pm));
      chk($sformatf("tbl%0d_sec", i),
        32'(disp_sec), 32'h00);
    end
    set_sel = 1'b0;
    mode24  = 1'b1;
    #1;
    chk("alm_edit_keeps_time", 32'(disp_hr), 32'h00);

    repeat (23) press(0, 1);
    repeat (59) press(1, 1);
    repeat (58) wait_tick();
    cyc();
    chk("set_hr", 32'(disp_hr), 32'h23);
    chk("set_min", 32'(disp_min), 32'h59);
    chk("set_sec", 32'(disp_sec), 32'h58);
    mode24 = 1'b0;
    #1;
    chk("set_hr12", 32'(disp_hr), 32'h11);
    chk("set_pm", 32'(disp_pm), 32'd1);
    mode24 = 1'b1;
    repeat (2) wait_tick();
    cyc();
    chk("wrap_hr", 32'(disp_hr), 32'h00);
    chk("wrap_min", 32'(disp_min), 32'h00);
    chk("wrap_sec", 32'(disp_sec), 32'h00);
    mode24 = 1'b0;
    #1;
    chk("wrap_hr12", 32'(disp_hr), 32'h12);
    chk("wrap_pm", 32'(disp_pm), 32'd0);
    mode24 = 1'b1;

    inc_min_n = 1'b0;
    cyc();
    chk("hold_min1", 32'(disp_min), 32'h01);
    chk("hold_sec0", 32'(disp_sec), 32'h00);
    repeat (29) cyc();
    chk("hold_min_still", 32'(disp_min), 32'h01);
    inc_min_n = 1'b1;
    cyc();
    chk("hold_release", 32'(disp_min), 32'h01);

    set_sel = 1'b1;
    alm_sel = 1'b0;
    press(1, 1);
    #1;
    chk("alm0_min", 32'(disp_min), 32'h01);
    set_sel = 1'b0;
    alm_en  = 2'b01;
    goto_ring(1'b0, "first");
    chk("first_time_min", 32'(disp_min), 32'h01);

    snooze_n = 1'b0;
    cyc();
    chk("snz_on", 32'(snoozed), 32'd1);
    chk("snz_ring_off", 32'(ring), 32'd0);
    snooze_n = 1'b1;
    repeat (59) wait_tick();
    cyc();
    chk("snz_59", 32'(snoozed), 32'd1);
    wait_tick();
    cyc();
    cyc();
    chk("snz_reRing", 32'(ring), 32'd1);
    chk("snz_off", 32'(snoozed), 32'd0);
    chk("snz_id", 32'(ring_id), 32'd0);
    stop_n = 1'b0;
    cyc();
    chk("stop_ring", 32'(ring), 32'd0);
    chk("stop_snz", 32'(snoozed), 32'd0);
    stop_n = 1'b1;
    cyc();

    set_sel = 1'b1;
    alm_sel = 1'b1;
    press(1, 1);
    set_sel = 1'b0;
    alm_en  = 2'b11;
    goto_ring(1'b0, "both");
    repeat (4) wait_tick();
    cyc();
    chk("tmo_pre", 32'(ring), 32'd1);
    wait_tick();
    chk("tmo_edge", 32'(ring), 32'd1);
    cyc();
    cyc();
    chk("tmo_off", 32'(ring), 32'd0);

    goto_ring(1'b0, "third");
    set_sel = 1'b1;
    alm_sel = 1'b0;
    press(0, 1);
    chk("edit_no_abort", 32'(ring), 32'd1);
    set_sel  = 1'b0;
    snooze_n = 1'b0;
    stop_n   = 1'b0;
    cyc();
    chk("stopsnz_ring", 32'(ring), 32'd0);
    chk("stopsnz_snz", 32'(snoozed), 32'd0);
    snooze_n = 1'b1;
    stop_n   = 1'b1;
    cyc();

    goto_ring(1'b1, "alm1");
    alm_en = 2'b01;
    cyc();
    chk("en_clr_ring", 32'(ring), 32'd0);
    chk("en_clr_snz", 32'(snoozed), 32'd0);

    alm_en = 2'b11;
    goto_ring(1'b1, "last");
    #2;
    AUD_DACLRCK = 1'b0;
    #1;
    chk("arst_ring", 32'(ring), 32'd0);
    chk("arst_id", 32'(ring_id), 32'd0);
    chk("arst_min", 32'(disp_min), 32'h00);
    @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
